// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam int          ENTRY_W = $bits(fetch_entry_t);

    // Instruction memory is word addressed; the byte offset is dropped.
    function automatic logic [31:0] pc_to_word_addr(input logic [31:0] pc);
        return {2'b00, pc[31:2]};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries toward decode.
// Flush wins over push; head is read straight from registered storage.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] push_data,
    output logic [ENTRY_W-1:0] head_data,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);

    fetch_entry_t  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Storage is cleared on reset so the head reads as zero while empty.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_reg[gi] <= '0;
            end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                mem_reg[gi] <= fetch_entry_t'(push_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one memory read at a time, buffers results.
// Optional misaligned-redirect fault enabled by INSTR_FETCH_ALIGN_CHECK_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_rd_addr,
    output logic        mem_rd_addr_valid,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
    output logic        fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   redirect_target;
    logic          fault_next;
    logic          push_req;
    logic          fifo_push;
    logic          fifo_flush;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          has_space;
    logic          can_req;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic fault_reg;

    // Sticky until a later aligned redirect; blocks all requests meanwhile.
    assign fault_next      = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fault_reg;
    assign redirect_target = redirect_pc;
    assign fetch_fault     = fault_reg;

    always_ff @(posedge clk) begin
        if (reset) fault_reg <= 1'b0;
        else       fault_reg <= fault_next;
    end
`else
    assign fault_next      = 1'b0;
    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign fetch_fault     = 1'b0;
`endif

    // Space is judged on the registered count, so a slot exists for the whole request.
    assign has_space = (fifo_count < CW'(FIFO_DEPTH));
    assign can_req   = has_space && !fault_next;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        push_req   = 1'b0;
        fifo_flush = 1'b0;
        case (state_reg)
            S_IDLE: if (can_req) state_next = S_REQ;
            S_REQ: begin
                if (mem_rd_ack) begin
                    push_req   = 1'b1;
                    pc_next    = pc_reg + PC_STEP;
                    state_next = S_GAP;
                end
            end
            // Memory re-acks while valid stays high; this idle cycle avoids a double capture.
            S_GAP:   state_next = can_req ? S_REQ : S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (redirect_valid) begin
            push_req   = 1'b0;
            fifo_flush = 1'b1;
            pc_next    = redirect_target;
            if (state_reg == S_REQ) state_next = S_GAP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    assign fifo_push  = push_req && !fifo_full;
    assign push_entry = '{pc: pc_reg, instr: mem_rd_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fetch_valid && fetch_ready),
        .flush     (fifo_flush),
        .push_data (push_entry),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign mem_rd_addr       = pc_to_word_addr(pc_reg);
    assign mem_rd_addr_valid = (state_reg == S_REQ);
    assign fetch_valid       = !fifo_empty;
    assign fetch_pc          = head_entry.pc;
    assign fetch_instr       = head_entry.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a registered-ack memory model.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_addr_valid;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rd_ack = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_count = 0;
    logic prev_valid = 1'b0;
    fetch_entry_t exp_q[$];
    fetch_entry_t exp_e;
    int          pop_cyc[$];
    logic [31:0] req_q[$];

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_addr_valid (mem_rd_addr_valid),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_ack        (mem_rd_ack),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_pc          (fetch_pc),
        .fetch_instr       (fetch_instr),
        .fetch_fault       (fetch_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word n holds (n+1)*0x11: words 0..3 = 0x11,0x22,0x33,0x44.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr + 32'd1) * 32'h11;
    endfunction

    always @(posedge clk) begin
        mem_rd_ack <= mem_rd_addr_valid;
        if (mem_rd_addr_valid) mem_rd_data <= mem_word(mem_rd_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted output, logs new requests.
    always @(negedge clk) begin
        if (fetch_valid && fetch_ready) begin
            $display("cycle %0d: fetch pc=%h instr=%h", cyc, fetch_pc, fetch_instr);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc=%h instr=%h, expected none", fetch_pc, fetch_instr);
            end else begin
                exp_e = exp_q.pop_front();
                check("out_pc", fetch_pc, exp_e.pc);
                check("out_instr", fetch_instr, exp_e.instr);
            end
            pop_count++;
            pop_cyc.push_back(cyc);
        end
        if (mem_rd_addr_valid && !prev_valid) req_q.push_back(mem_rd_addr);
        prev_valid = mem_rd_addr_valid;
        if (dut.push_req && dut.fifo_full) begin
            checks++;
            errors++;
            $display("FAIL push_into_full: got push with count=%0d, expected no push", dut.fifo_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (pop_count < target && n < budget) begin
            step();
            n++;
        end
        check("pop_progress", 32'(pop_count >= target), 32'd1);
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        step();
        reset = 1'b0;
        req_q.delete();
        pop_cyc.delete();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
        req_q.delete();
    endtask

    initial begin
        int base;
        bit found;

        repeat (3) step();
        @(negedge clk);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_pc", fetch_pc, 32'd0);
        check("rst_fetch_instr", fetch_instr, 32'd0);
        check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        check("rst_addr_valid", 32'(mem_rd_addr_valid), 32'd0);
        check("rst_addr", mem_rd_addr, 32'd0);

        // Streaming with decode always ready.
        step();
        expect_out(32'h0, 32'h11);
        expect_out(32'h4, 32'h22);
        expect_out(32'h8, 32'h33);
        expect_out(32'hC, 32'h44);
        reset       = 1'b0;
        fetch_ready = 1'b1;
        @(negedge clk);
        check("first_cycle0_valid", 32'(mem_rd_addr_valid), 32'd0);
        step();
        @(negedge clk);
        check("first_cycle1_valid", 32'(mem_rd_addr_valid), 32'd1);
        check("first_cycle1_addr", mem_rd_addr, 32'd0);
        wait_pops(4, 40);
        check("stream_pops", 32'(pop_cyc.size()), 32'd4);
        for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
            check("stream_interval", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd3);
        check("stream_reqs", 32'(req_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < req_q.size(); i++)
            check("stream_addr", req_q[i], 32'(i));

        // Reset in the middle of a request.
        check("mid_req_valid", 32'(mem_rd_addr_valid), 32'd1);
        apply_reset();
        @(negedge clk);
        check("rst_mid_valid", 32'(mem_rd_addr_valid), 32'd0);
        check("rst_mid_fetch_valid", 32'(fetch_valid), 32'd0);
        step();
        @(negedge clk);
        check("stale_ack_no_push", 32'(fetch_valid), 32'd0);
        check("restart_addr_valid", 32'(mem_rd_addr_valid), 32'd1);
        check("restart_addr", mem_rd_addr, 32'd0);

        // Back-pressure: only two reads fit, then resume without gaps.
        expect_out(32'h0, 32'h11);
        expect_out(32'h4, 32'h22);
        expect_out(32'h8, 32'h33);
        expect_out(32'hC, 32'h44);
        repeat (20) step();
        check("bp_req_count", 32'(req_q.size()), 32'd2);
        check("bp_fetch_valid", 32'(fetch_valid), 32'd1);
        check("bp_head_pc", fetch_pc, 32'h0);
        base        = pop_count;
        fetch_ready = 1'b1;
        wait_pops(base + 4, 40);
        apply_reset();

        // Redirect coinciding with the ack for PC 8.
        expect_out(32'h0, 32'h11);
        expect_out(32'h4, 32'h22);
        expect_out(32'h40, 32'h121);
        expect_out(32'h44, 32'h132);
        base        = pop_count;
        fetch_ready = 1'b1;
        found       = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (mem_rd_ack && mem_rd_addr_valid && mem_rd_addr == 32'd2) found = 1'b1;
        end
        check("redir_ack_seen", 32'(found), 32'd1);
        do_redirect(32'h40);
        @(negedge clk);
        check("redir_gap_valid", 32'(mem_rd_addr_valid), 32'd0);
        check("redir_flush", 32'(fetch_valid), 32'd0);
        step();
        @(negedge clk);
        check("redir_req_valid", 32'(mem_rd_addr_valid), 32'd1);
        check("redir_req_addr", mem_rd_addr, 32'h10);
        wait_pops(base + 4, 40);

        // PC wrap at the top of the address space.
        expect_out(32'hFFFF_FFFC, 32'h4000_0000);
        expect_out(32'h0, 32'h11);
        base = pop_count;
        do_redirect(32'hFFFF_FFFC);
        wait_pops(base + 2, 40);
        check("wrap_reqs", 32'(req_q.size() >= 2), 32'd1);
        if (req_q.size() >= 2) begin
            check("wrap_addr_top", req_q[0], 32'h3FFF_FFFF);
            check("wrap_addr_zero", req_q[1], 32'h0);
        end

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        // Misaligned redirect faults and stalls; an aligned one recovers.
        do_redirect(32'h42);
        repeat (10) step();
        check("align_fault_set", 32'(fetch_fault), 32'd1);
        check("align_no_reqs", 32'(req_q.size()), 32'd0);
        check("align_flushed", 32'(fetch_valid), 32'd0);
        expect_out(32'h44, 32'h132);
        base = pop_count;
        do_redirect(32'h44);
        check("align_fault_clear", 32'(fetch_fault), 32'd0);
        wait_pops(base + 1, 40);
`else
        // Low PC bits are dropped on redirect and no fault is raised.
        expect_out(32'h40, 32'h121);
        base = pop_count;
        do_redirect(32'h42);
        check("noalign_fault", 32'(fetch_fault), 32'd0);
        wait_pops(base + 1, 40);
        check("noalign_reqs", 32'(req_q.size() >= 1), 32'd1);
        if (req_q.size() >= 1) check("noalign_addr", req_q[0], 32'h10);
`endif

        apply_reset();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
